instr_fetch_unit: RTL and testbench

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/instr_fetch_unit_pkg.sv | 16 +
 rtl/instr_fetch_unit_buffer.sv | 61 ++++++
 rtl/instr_fetch_unit.sv | 81 ++++++++
 tb/tb_instr_fetch_unit.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared widths, buffer depth and fetch FSM encoding for the instruction fetch slice.
package instr_fetch_unit_pkg;

    localparam int WORD_W          = 32;
    localparam int FETCH_BUF_DEPTH = 2;

    // Occupancy at which the buffer can take no further words.
    localparam logic [1:0] BUF_FULL = 2'(FETCH_BUF_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_buffer.sv
// Two-entry shifting buffer of {instruction, pc}; slot0 is always the head.
module fetch_buffer
    import instr_fetch_unit_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  clear,
    input  logic [0:2*WORD_W-1]   din,
    output logic [0:2*WORD_W-1]   head,
    output logic [1:0]            count
);

    logic [0:2*WORD_W-1] slot0;
    logic [0:2*WORD_W-1] slot1;

    // A simultaneous push and pop keeps occupancy and moves the new word toward the head.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot0 <= '0;
            slot1 <= '0;
            count <= 2'd0;
        end else if (clear) begin
            count <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        slot0 <= din;
                        count <= count + 2'd1;
                    end else if (count < BUF_FULL) begin
                        slot1 <= din;
                        count <= count + 2'd1;
                    end
                end
                2'b01: begin
                    if (count != 2'd0) begin
                        slot0 <= slot1;
                        count <= count - 2'd1;
                    end
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        slot0 <= din;
                    end else if (count == BUF_FULL) begin
                        slot0 <= slot1;
                        slot1 <= din;
                    end else begin
                        slot0 <= din;
                        count <= 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign head = slot0;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: one outstanding memory read at a time, results queued in a 2-entry buffer.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [0:WORD_W-1]   pc_in,
    input  logic                pc_valid,
    output logic                pc_accept,
    input  logic                flush,
    output logic                imem_req,
    output logic [0:WORD_W-1]   imem_addr,
    input  logic                imem_ack,
    input  logic [0:WORD_W-1]   imem_data,
    output logic [0:WORD_W-1]   instr_out,
    output logic [0:WORD_W-1]   instr_pc,
    output logic                instr_valid,
    input  logic                instr_ready
);

    fetch_state_t          state;
    fetch_state_t          state_next;
    logic [0:WORD_W-1]     tag_pc;
    logic [1:0]            count;
    logic                  push;
    logic                  pop;
    logic [0:2*WORD_W-1]   head;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            imem_req  <= 1'b0;
            imem_addr <= '0;
            tag_pc    <= '0;
        end else begin
            state    <= state_next;
            imem_req <= pc_accept;
            if (pc_accept) begin
                imem_addr <= pc_in;
                tag_pc    <= pc_in;
            end
        end
    end

    // Admission only from IDLE with a free slot, so a returning word always fits.
    always_comb begin
        state_next = state;
        pc_accept  = pc_valid & ~flush & ~rst & (state == IDLE) & (count < BUF_FULL);
        push       = (state == WAIT) & imem_ack & ~flush;
        pop        = instr_valid & instr_ready;
        case (state)
            IDLE: begin
                if (pc_accept) state_next = WAIT;
            end
            WAIT: begin
                if (imem_ack)   state_next = IDLE;
                else if (flush) state_next = DRAIN;
            end
            DRAIN: begin
                if (imem_ack) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    fetch_buffer u_fetch_buffer (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .clear (flush),
        .din   ({imem_data, tag_pc}),
        .head  (head),
        .count (count)
    );

    assign instr_valid = (count != 2'd0);
    assign instr_out   = head[0:WORD_W-1];
    assign instr_pc    = head[WORD_W:2*WORD_W-1];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with hand-computed expectations.
module tb_instr_fetch_unit;
    import instr_fetch_unit_pkg::*;

    logic        clk;
    logic        rst;
    logic [0:31] pc_in;
    logic        pc_valid;
    logic        pc_accept;
    logic        flush;
    logic        imem_req;
    logic [0:31] imem_addr;
    logic        imem_ack;
    logic [0:31] imem_data;
    logic [0:31] instr_out;
    logic [0:31] instr_pc;
    logic        instr_valid;
    logic        instr_ready;

    int testsRun    = 0;
    int testsFailed = 0;

    instr_fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .pc_in       (pc_in),
        .pc_valid    (pc_valid),
        .pc_accept   (pc_accept),
        .flush       (flush),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_data   (imem_data),
        .instr_out   (instr_out),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One fetch with a 1-cycle ack; the word is buffered when this returns.
    task automatic applyStimulus(input logic [31:0] pc, input logic [31:0] data);
        pc_valid = 1'b1;
        pc_in    = pc;
        #1;
        checkOutput("fetch_accept", 64'(pc_accept), 64'd1);
        tick();
        pc_valid = 1'b0;
        checkOutput("fetch_addr", 64'(imem_addr), 64'(pc));
        tick();
        imem_ack  = 1'b1;
        imem_data = data;
        tick();
        imem_ack  = 1'b0;
    endtask

    initial begin
        rst = 1'b1; pc_in = '0; pc_valid = 1'b0; flush = 1'b0;
        imem_ack = 1'b0; imem_data = '0; instr_ready = 1'b0;

        // Reset state, and pc_accept held low during reset
        tick();
        pc_valid = 1'b1; pc_in = 32'h7;
        #1;
        checkOutput("rst_pc_accept", 64'(pc_accept), 64'd0);
        tick();
        pc_valid = 1'b0; rst = 1'b0;
        checkOutput("rst_valid", 64'(instr_valid), 64'd0);
        checkOutput("rst_req", 64'(imem_req), 64'd0);
        checkOutput("rst_addr", 64'(imem_addr), 64'd0);
        checkOutput("rst_out", 64'(instr_out), 64'd0);
        checkOutput("rst_pc", 64'(instr_pc), 64'd0);
        checkOutput("rst_state", 64'(dut.state), 64'(IDLE));

        // Basic fetch with minimum latency
        pc_valid = 1'b1; pc_in = 32'h0000_0005;
        #1;
        checkOutput("basic_accept", 64'(pc_accept), 64'd1);
        tick();
        pc_valid = 1'b0;
        checkOutput("basic_req", 64'(imem_req), 64'd1);
        checkOutput("basic_addr", 64'(imem_addr), 64'd5);
        checkOutput("basic_state", 64'(dut.state), 64'(WAIT));
        tick();
        checkOutput("basic_req_pulse", 64'(imem_req), 64'd0);
        checkOutput("basic_addr_held", 64'(imem_addr), 64'd5);
        checkOutput("basic_not_yet", 64'(instr_valid), 64'd0);
        imem_ack = 1'b1; imem_data = 32'hDEAD_BEEF;
        tick();
        imem_ack = 1'b0;
        checkOutput("basic_valid", 64'(instr_valid), 64'd1);
        checkOutput("basic_out", 64'(instr_out), 64'hDEAD_BEEF);
        checkOutput("basic_pc", 64'(instr_pc), 64'd5);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        checkOutput("basic_popped", 64'(instr_valid), 64'd0);

        // Backpressure: two words fill the buffer, third pc refused until a pop
        applyStimulus(32'd0, 32'hA000_0000);
        applyStimulus(32'd1, 32'hA000_0001);
        checkOutput("bp_count2", 64'(dut.count), 64'd2);
        pc_valid = 1'b1; pc_in = 32'd2;
        #1;
        checkOutput("bp_refuse", 64'(pc_accept), 64'd0);
        tick();
        checkOutput("bp_refuse_hold", 64'(pc_accept), 64'd0);
        checkOutput("bp_stable_out", 64'(instr_out), 64'hA000_0000);
        checkOutput("bp_stable_pc", 64'(instr_pc), 64'd0);
        instr_ready = 1'b1;
        #1;
        checkOutput("bp_refuse_at_pop", 64'(pc_accept), 64'd0);
        tick();
        instr_ready = 1'b0;
        #1;
        checkOutput("bp_accept_after_pop", 64'(pc_accept), 64'd1);
        checkOutput("bp_head_pc1", 64'(instr_pc), 64'd1);
        tick();
        pc_valid = 1'b0;
        checkOutput("bp_addr2", 64'(imem_addr), 64'd2);
        tick();
        imem_ack = 1'b1; imem_data = 32'hA000_0002;
        tick();
        imem_ack = 1'b0;
        checkOutput("bp_refill", 64'(dut.count), 64'd2);
        instr_ready = 1'b1;
        tick();
        checkOutput("bp_head_pc2", 64'(instr_pc), 64'd2);
        checkOutput("bp_head_out2", 64'(instr_out), 64'hA000_0002);
        tick();
        instr_ready = 1'b0;
        checkOutput("bp_empty", 64'(instr_valid), 64'd0);

        // Flush while waiting, ack three cycles after the request
        pc_valid = 1'b1; pc_in = 32'd8;
        #1;
        checkOutput("fl_accept", 64'(pc_accept), 64'd1);
        tick();
        pc_in = 32'd9;
        checkOutput("fl_req", 64'(imem_req), 64'd1);
        checkOutput("fl_addr", 64'(imem_addr), 64'd8);
        tick();
        tick();
        flush = 1'b1;
        #1;
        checkOutput("fl_accept_flush", 64'(pc_accept), 64'd0);
        tick();
        flush = 1'b0;
        checkOutput("fl_state_drain", 64'(dut.state), 64'(DRAIN));
        imem_ack = 1'b1; imem_data = 32'hBAD0_0008;
        #1;
        checkOutput("fl_accept_drain", 64'(pc_accept), 64'd0);
        tick();
        imem_ack = 1'b0;
        checkOutput("fl_state_idle", 64'(dut.state), 64'(IDLE));
        checkOutput("fl_no_data", 64'(instr_valid), 64'd0);
        checkOutput("fl_accept_after", 64'(pc_accept), 64'd1);
        tick();
        pc_valid = 1'b0;
        checkOutput("fl_addr9", 64'(imem_addr), 64'd9);
        tick();
        imem_ack = 1'b1; imem_data = 32'h0000_9999;
        tick();
        imem_ack = 1'b0;
        checkOutput("fl_word9_pc", 64'(instr_pc), 64'd9);
        checkOutput("fl_word9_out", 64'(instr_out), 64'h0000_9999);

        // Flush and ack together with one word buffered
        pc_valid = 1'b1; pc_in = 32'd10;
        #1;
        checkOutput("fa_accept", 64'(pc_accept), 64'd1);
        tick();
        pc_valid = 1'b0;
        tick();
        imem_ack = 1'b1; flush = 1'b1; imem_data = 32'h0000_AAAA;
        tick();
        imem_ack = 1'b0; flush = 1'b0;
        checkOutput("fa_count", 64'(dut.count), 64'd0);
        checkOutput("fa_valid", 64'(instr_valid), 64'd0);
        checkOutput("fa_state", 64'(dut.state), 64'(IDLE));
        pc_valid = 1'b1; pc_in = 32'd11;
        #1;
        checkOutput("fa_new_accept", 64'(pc_accept), 64'd1);
        tick();
        pc_valid = 1'b0;
        checkOutput("fa_addr11", 64'(imem_addr), 64'd11);
        tick();
        imem_ack = 1'b1; imem_data = 32'h0000_0B11;
        tick();
        imem_ack = 1'b0;
        checkOutput("fa_count1", 64'(dut.count), 64'd1);

        // Ack in IDLE is ignored
        imem_ack = 1'b1; imem_data = 32'hFFFF_FFFF;
        tick();
        imem_ack = 1'b0;
        checkOutput("idle_ack_count", 64'(dut.count), 64'd1);
        checkOutput("idle_ack_head", 64'(instr_pc), 64'd11);

        // Simultaneous push and pop at count 1
        pc_valid = 1'b1; pc_in = 32'd12;
        tick();
        pc_valid = 1'b0;
        tick();
        imem_ack = 1'b1; imem_data = 32'h0000_0C12; instr_ready = 1'b1;
        tick();
        imem_ack = 1'b0; instr_ready = 1'b0;
        checkOutput("pp_count", 64'(dut.count), 64'd1);
        checkOutput("pp_head_pc", 64'(instr_pc), 64'd12);
        checkOutput("pp_head_out", 64'(instr_out), 64'h0000_0C12);

        // Reset while a request is outstanding; the late ack is ignored
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        pc_valid = 1'b1; pc_in = 32'd20;
        tick();
        pc_valid = 1'b0;
        checkOutput("rw_req", 64'(imem_req), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        imem_ack = 1'b1; imem_data = 32'h0000_0E20;
        tick();
        imem_ack = 1'b0;
        checkOutput("rw_valid", 64'(instr_valid), 64'd0);
        checkOutput("rw_req_low", 64'(imem_req), 64'd0);
        checkOutput("rw_addr", 64'(imem_addr), 64'd0);
        checkOutput("rw_out", 64'(instr_out), 64'd0);
        checkOutput("rw_pc", 64'(instr_pc), 64'd0);
        checkOutput("rw_state", 64'(dut.state), 64'(IDLE));
        tick();
        checkOutput("rw_valid_late", 64'(instr_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
